car_detector: RTL
=================

// Module: car_detector
// PURPOSE
//  Front end of the parking-lot occupancy path. Two photo-sensors A (outer) and B (inner) are raw async inputs.
//  The block synchronizes and debounces them, then tracks the A/B sequence with an FSM.
//  Emits single-cycle enter/exit pulses that drive the in/out inputs of the downstream occupancy counter.
//  Aborted passes (car backs out) and illegal sequences produce no enter/exit pulse.
// PARAMETERS
//  SYNC_STAGES      2  flip-flops per sensor in the synchronizer chain (>=2)
//  DEBOUNCE_CYCLES  4  consecutive identical synchronized samples required before a new {A,B} value is accepted (>=1)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  reset     in   1  asynchronous, active-high; clears all state
//  a         in   1  raw outer sensor, 1 = beam blocked, asynchronous
//  b         in   1  raw inner sensor, 1 = beam blocked, asynchronous
//  enter     out  1  one-cycle pulse: car completed entry -> counter in
//  exit      out  1  one-cycle pulse: car completed exit -> counter out
//  error     out  1  one-cycle pulse: illegal sensor transition detected
//  occupied  out  1  level: debounced {A,B} != 2'b00
// BEHAVIOUR
//  Reset: all sync/debounce flops 0, debounced pair 2'b00, FSM IDLE; enter=exit=error=occupied=0.
//  Debounce: the debounced pair changes only after the synchronized pair holds a new value DEBOUNCE_CYCLES consecutive edges.
//   Any change restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles are invisible.
//  FSM steps on debounced-pair changes only. Notation {A,B}:
//   IDLE:  10->ENT1; 01->EXT1; 11->ERR
//   ENT1:  11->ENT2; 00->IDLE (abort); 01->ERR
//   ENT2:  01->ENT3; 10->ENT1 (reversing); 00->ERR
//   ENT3:  00->IDLE + enter pulse; 11->ENT2; 10->ERR
//   EXT1:  11->EXT2; 00->IDLE (abort); 10->ERR
//   EXT2:  10->EXT3; 01->EXT1; 00->ERR
//   EXT3:  00->IDLE + exit pulse; 11->EXT2; 01->ERR
//   ERR:   error pulse on entry (one cycle); stays until debounced pair == 00, then ->IDLE, no pulse
//  Outputs are registered, high exactly one cycle, asserted on the same edge as the FSM transition.
//   enter, exit and error are mutually exclusive.
//  Latency: raw pair reaching a new stable value sampled first at edge k -> FSM/outputs update at edge k+SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
//  Back-to-back cars: a new pass may start the cycle after return to IDLE; no dead time.
//  Ordering: a and b changing in the same raw cycle are treated as one pair change (e.g. 10->01 from ENT1 -> ERR).
//  Reset mid-pass: FSM returns to IDLE and any pending pulse is dropped. After release, a car already present
//   starts from IDLE with its current pair, so e.g. 11 -> ERR, and it is never counted.
//  Downstream contract: a pulse is produced whether or not the lot is full or empty. Saturation is the counter's job.
// STRUCTURE
//  car_detect_pkg: typedef enum logic [2:0] det_state_t {IDLE,ENT1,ENT2,ENT3,EXT1,EXT2,EXT3,ERR};
//   localparam logic [1:0] AB_NONE=2'b00, AB_A=2'b10, AB_B=2'b01, AB_BOTH=2'b11.
//  Sub-module sensor_debounce #(WIDTH=2,SYNC_STAGES,DEBOUNCE_CYCLES):
//   sync chain + stability counter ($clog2(DEBOUNCE_CYCLES+1) bits, saturating) + debounced register.
//   Instantiated once on {a,b}. car_detector top holds the FSM and output registers.
// TESTING (defaults, 100-unit clock)
//  1 Entry: {a,b}=10,11,01,00, each held 8 cycles -> exactly one enter pulse, 6 edges after 00 applied; exit=error=0.
//  2 Exit + back-to-back: 01,11,10,00 then immediately 10,11,01,00 -> one exit pulse then one enter pulse, each 1 cycle wide.
//  3 Abort/reversal: 10,11,10,00 and 10,00 -> no pulses; FSM ends in IDLE; occupied high only while pair != 00.
//  4 Glitch: from 00, a=1 for 3 cycles then 0 -> no FSM change, occupied stays 0.
//    The same test with a 4-cycle hold -> occupied rises.
//  5 Illegal: 00 -> 11 directly -> one error pulse; with b held high, no further pulses until 00; then a legal entry -> enter.
//  6 Reset mid-pass: assert reset async between clock edges in ENT2 -> all outputs 0 immediately.
//    After release with pair 00, a full entry yields exactly one enter pulse.
//  Bench also hooks enter/exit into counter and checks cars count after 20 entries and 10 exits = 10.

Source files
------------

// File: rtl/car_detect_pkg.sv
// Shared types for the car detector: FSM state encoding and named {A,B} sensor pairs.
package car_detect_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENT1,
        ENT2,
        ENT3,
        EXT1,
        EXT2,
        EXT3,
        ERR
    } det_state_t;

    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizes an asynchronous bus and accepts a new value only after it has been
// stable for DEBOUNCE_CYCLES consecutive synchronized samples.
module sensor_debounce #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] stage_in [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] last_reg;
    logic [WIDTH-1:0] deb_reg, deb_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign stage_in[gi] = din;
            end else begin : g_rest
                assign stage_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // A changed sample counts as the first of a new run; the count saturates at the threshold.
    always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        if (sync_out != last_reg) begin
            cnt_next = CNT_ONE;
        end else if (cnt_reg < CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
        if (cnt_next >= CNT_MAX) begin
            deb_next = sync_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
            last_reg <= '0;
            cnt_reg  <= '0;
            deb_reg  <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= stage_in[i];
            end
            last_reg <= sync_out;
            cnt_reg  <= cnt_next;
            deb_reg  <= deb_next;
        end
    end

    assign dout = deb_reg;

endmodule

// File: rtl/car_detector.sv
// Parking-lot gate front end: debounced A/B sensor pair tracked by an FSM that
// emits one-cycle enter/exit/error pulses and an occupied level.
module car_detector
    import car_detect_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter,
    output logic exit,
    output logic error,
    output logic occupied
);

    logic [1:0] pair;
    det_state_t state_reg, state_next;
    logic enter_reg, enter_next;
    logic exit_reg, exit_next;
    logic error_reg, error_next;
    logic occupied_reg, occupied_next;

    sensor_debounce #(
        .WIDTH          (2),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .din  ({a, b}),
        .dout (pair)
    );

    // Each non-error state has one resident pair, so reacting to the level of the
    // debounced pair is the same as reacting to its changes.
    always_comb begin
        state_next    = state_reg;
        enter_next    = 1'b0;
        exit_next     = 1'b0;
        error_next    = 1'b0;
        occupied_next = (pair != AB_NONE);
        unique case (state_reg)
            IDLE: begin
                if (pair == AB_A)         state_next = ENT1;
                else if (pair == AB_B)    state_next = EXT1;
                else if (pair == AB_BOTH) begin state_next = ERR; error_next = 1'b1; end
            end
            ENT1: begin
                if (pair == AB_BOTH)      state_next = ENT2;
                else if (pair == AB_NONE) state_next = IDLE;
                else if (pair == AB_B)    begin state_next = ERR; error_next = 1'b1; end
            end
            ENT2: begin
                if (pair == AB_B)         state_next = ENT3;
                else if (pair == AB_A)    state_next = ENT1;
                else if (pair == AB_NONE) begin state_next = ERR; error_next = 1'b1; end
            end
            ENT3: begin
                if (pair == AB_NONE)      begin state_next = IDLE; enter_next = 1'b1; end
                else if (pair == AB_BOTH) state_next = ENT2;
                else if (pair == AB_A)    begin state_next = ERR; error_next = 1'b1; end
            end
            EXT1: begin
                if (pair == AB_BOTH)      state_next = EXT2;
                else if (pair == AB_NONE) state_next = IDLE;
                else if (pair == AB_A)    begin state_next = ERR; error_next = 1'b1; end
            end
            EXT2: begin
                if (pair == AB_A)         state_next = EXT3;
                else if (pair == AB_B)    state_next = EXT1;
                else if (pair == AB_NONE) begin state_next = ERR; error_next = 1'b1; end
            end
            EXT3: begin
                if (pair == AB_NONE)      begin state_next = IDLE; exit_next = 1'b1; end
                else if (pair == AB_BOTH) state_next = EXT2;
                else if (pair == AB_B)    begin state_next = ERR; error_next = 1'b1; end
            end
            ERR: begin
                if (pair == AB_NONE)      state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            enter_reg    <= 1'b0;
            exit_reg     <= 1'b0;
            error_reg    <= 1'b0;
            occupied_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            enter_reg    <= enter_next;
            exit_reg     <= exit_next;
            error_reg    <= error_next;
            occupied_reg <= occupied_next;
        end
    end

    assign enter    = enter_reg;
    assign exit     = exit_reg;
    assign error    = error_reg;
    assign occupied = occupied_reg;

endmodule
